// File: rtl/mem_dump_tx_pkg.sv
// rtl/mem_dump_tx_pkg.sv - shared debug package: dump FSM states and word/byte sizing
package mem_dump_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } dump_state_t;

  function automatic int bytes_per_word(input int word_bits);
    return word_bits / 8;
  endfunction

  localparam int DEFAULT_BYTES_PER_WORD = bytes_per_word(32);

endpackage

// File: rtl/mem_dump_tx.sv
// rtl/mem_dump_tx.sv - streams the halted data memory out as MSB-first bytes
module mem_dump_tx
  import mem_dump_tx_pkg::*;
#(
  parameter int len_data  = 32,
  parameter int len_addr  = 6,
  parameter int num_words = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic                start,
  input  logic [len_data-1:0] mem_rd_data,
  input  logic                tx_ready,
  output logic                mem_rd_en,
  output logic [len_addr-1:0] mem_addr,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  output logic                busy,
  output logic                done
);

  localparam int BPW   = bytes_per_word(len_data);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [len_addr-1:0] LAST_ADDR = len_addr'(num_words - 1);
  localparam logic [IDX_W-1:0]    LAST_BYTE = IDX_W'(BPW - 1);

  dump_state_t         state, state_nx;
  logic [len_addr-1:0] counter;
  logic [IDX_W-1:0]    byte_idx;
  logic [len_data-1:0] shift_reg;
  logic                xfer;
  logic                last_byte;

  assign xfer      = (state == ST_SEND) && tx_ready;
  assign last_byte = (byte_idx == LAST_BYTE);

  always_comb begin
    state_nx  = state;
    mem_rd_en = 1'b0;
    tx_valid  = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start && halt) state_nx = ST_REQ;
      ST_REQ: begin
        mem_rd_en = 1'b1;
        state_nx  = ST_WAIT;
      end
      ST_WAIT: state_nx = ST_SEND;
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && last_byte)
          state_nx = (counter == LAST_ADDR) ? ST_DONE : ST_REQ;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign mem_addr = counter;
  assign tx_data  = shift_reg[len_data-1 -: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      counter   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && state_nx == ST_REQ)
        counter <= '0;
      if (state == ST_WAIT) begin
        shift_reg <= mem_rd_data;
        byte_idx  <= '0;
      end
      if (xfer) begin
        shift_reg <= shift_reg << 8;
        byte_idx  <= byte_idx + IDX_W'(1);
        // The final word leaves the counter parked so mem_addr never wraps.
        if (last_byte && counter != LAST_ADDR)
          counter <= counter + len_addr'(1);
      end
    end
  end

endmodule

// File: doc/mem_dump_tx.md
MEM_DUMP_TX -- requirements
Module: mem_dump_tx

Interface
REQ-001 The block SHALL provide parameter len_data, default 32, data memory word width in bits.
REQ-002 The block SHALL provide parameter len_addr, default 6, data memory address width in bits.
REQ-003 The block SHALL provide parameter num_words, default 64, number of words dumped per run.
REQ-004 Port clk, input, 1, clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, reset, asynchronous, active-high.
REQ-006 Port halt, input, 1, pipeline halted (registered MEM/WB halt flag); dump permitted only while high.
REQ-007 Port start, input, 1, single-cycle dump request.
REQ-008 Port mem_rd_data, input, len_data, data memory read port output.
REQ-009 Port tx_ready, input, 1, byte transmitter can accept a byte this cycle.
REQ-010 Port mem_rd_en, output, 1, data memory read enable.
REQ-011 Port mem_addr, output, len_addr, data memory word address.
REQ-012 Port tx_data, output, 8, byte offered to transmitter.
REQ-013 Port tx_valid, output, 1, tx_data valid.
REQ-014 Port busy, output, 1, high in every state except IDLE.
REQ-015 Port done, output, 1, one-cycle pulse at end of dump.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, SEND, DONE.
REQ-017 IDLE -> REQ when start=1 and halt=1 in the same cycle; start with halt=0 SHALL be ignored.
REQ-018 Entering REQ from IDLE SHALL clear the word address counter to 0.
REQ-019 REQ: mem_rd_en=1 for exactly one cycle with mem_addr=counter; next state WAIT.
REQ-020 WAIT: mem_rd_data SHALL be captured into a len_data shift register at the end of this cycle (one-cycle read latency); byte index cleared to 0; next state SEND.
REQ-021 SEND: tx_valid=1, tx_data = shift register bits [len_data-1 : len_data-8] (MSB-first byte order).
REQ-022 A byte SHALL transfer only on a cycle with tx_valid=1 and tx_ready=1; tx_data SHALL remain stable while tx_valid=1 and tx_ready=0.
REQ-023 On each transfer the shift register SHALL shift left 8 bits and byte index SHALL increment.
REQ-024 After the transfer of byte len_data/8-1: if counter = num_words-1 next state DONE, else counter increments by 1 and next state REQ.
REQ-025 DONE: done=1 for one cycle; next state IDLE.
REQ-026 mem_addr SHALL hold the counter value in all states; counter SHALL NOT wrap within a run.
REQ-027 halt falling during a run SHALL NOT abort it; start during a run SHALL be ignored.
REQ-028 tx_valid, mem_rd_en, done SHALL be 0 in IDLE, WAIT, DONE (except done in DONE).
REQ-029 A run SHALL transfer exactly num_words*len_data/8 bytes (256 at defaults), word 0 first.

Reset
REQ-030 On reset: state IDLE, counter 0, byte index 0, shift register 0; mem_rd_en, tx_valid, busy, done = 0; tx_data = 0; mem_addr = 0.
REQ-031 Reset asserted mid-run SHALL abort immediately with no further byte offered; no done pulse.

Structure
REQ-032 FSM state encodings and the bytes-per-word constant (len_data/8) SHALL reside in a shared debug package.
REQ-033 The block SHALL be a single module with no sub-modules; memory and transmitter are external.

Verification
REQ-034 Memory preloaded word0=0x12345678, word1=0xDEADBEEF, tx_ready=1, halt=1, start pulse -> bytes 12,34,56,78,DE,AD,BE,EF first, 256 bytes total, one done pulse, busy low after.
REQ-035 start pulse with halt=0 -> busy stays 0, no mem_rd_en, no tx_valid for 20 cycles.
REQ-036 tx_ready held 0 for 5 cycles during byte 2 of word 0 (0x56) -> tx_data stays 0x56, tx_valid stays 1, no byte lost or duplicated.
REQ-037 Reset asserted during word 10 -> outputs at reset values same cycle; later start with halt=1 restarts at mem_addr=0.
REQ-038 Second start pulse during run, halt dropped mid-run -> run completes, 256 bytes, single done pulse.
REQ-039 num_words=2 build -> exactly 8 bytes, mem_addr sequence 0,1, done after last byte, mem_addr never reaches 2.
